ahb_sram_slave: RTL and testbench

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_pkg.sv | 45 ++++
 rtl/ahb_sram_mem.sv | 25 ++
 rtl/ahb_sram_slave.sv | 131 +++++++++++++
 tb/tb_ahb_sram_slave.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the SRAM slave FSM state type and
// size/alignment helpers used by the slave datapath.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

    // Little-endian byte-lane enables for a 32-bit bus.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] m;
        m = '0;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << a;
            HSIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: m = '1;
            default:    m = '0;
        endcase
        return m;
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] a);
        return (size > HSIZE_WORD) ||
               ((size == HSIZE_HALF) && a[0]) ||
               ((size == HSIZE_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// DEPTH x 32 storage with per-byte-lane write enables and asynchronous read.
module ahb_sram_mem #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = 10
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: configurable wait states, two-cycle ERROR response
// for misaligned/oversized/out-of-range transfers, byte-lane writes.
module ahb_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic [2:0]            HBURST,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    import ahb_pkg::*;

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    slave_state_e          state;
    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic                  active_q;

    logic                  accept;
    logic                  illegal;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  final_cycle;
    logic [3:0]            mem_we;
    logic [31:0]           mem_rdata;

    assign accept   = HSEL && HREADY &&
                      ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign word_idx = HADDR >> 2;
    assign illegal  = misaligned(HSIZE, HADDR[1:0]) ||
                      (word_idx >= ADDR_WIDTH'(DEPTH));

    // active_q marks a legal data phase; with zero wait states it runs in ST_IDLE.
    assign final_cycle = active_q && HREADYOUT;
    assign mem_we      = (final_cycle && write_q && HRESETn) ?
                         lane_mask(size_q, addr_q[1:0]) : '0;
    assign HRDATA      = (final_cycle && !write_q) ? mem_rdata : '0;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= '0;
            active_q  <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    if (accept) begin
                        addr_q   <= HADDR;
                        write_q  <= HWRITE;
                        size_q   <= HSIZE;
                        wait_cnt <= 4'(WAIT_STATES);
                        if (illegal) begin
                            state     <= ST_ERR1;
                            active_q  <= 1'b0;
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state     <= ST_WAIT;
                            active_q  <= 1'b1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_OKAY;
                        end else begin
                            state     <= ST_IDLE;
                            active_q  <= 1'b1;
                            HREADYOUT <= 1'b1;
                            HRESP     <= HRESP_OKAY;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        active_q  <= 1'b0;
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                end
                default: begin
                    state     <= ST_IDLE;
                    active_q  <= 1'b0;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                end
            endcase
        end
    end

    ahb_sram_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk   (HCLK),
        .addr  (addr_q[IDX_W+1:2]),
        .we    (mem_we),
        .wdata (HWDATA[31:0]),
        .rdata (mem_rdata)
    );

    logic unused_ok;
    assign unused_ok = ^{HPROT, HBURST, addr_q};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave at 0, 2 and 3 wait states; expected
// responses are queued at each address phase and checked at data-phase end.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic [2:0]  hsel = '0;
    logic [31:0] haddr = '0;
    logic [31:0] hwdata = '0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = HTRANS_IDLE;
    logic [2:0]  hsize = HSIZE_WORD;
    logic        hready_o [3];
    logic        hresp [3];
    logic [31:0] hrdata [3];

    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) dut_ws0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(haddr), .HWRITE(hwrite),
        .HWDATA(hwdata), .HTRANS(htrans), .HSIZE(hsize), .HPROT(4'b0011), .HBURST(3'b000),
        .HREADY(hready_o[0]), .HRDATA(hrdata[0]), .HREADYOUT(hready_o[0]), .HRESP(hresp[0]));

    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(2)) dut_ws2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(haddr), .HWRITE(hwrite),
        .HWDATA(hwdata), .HTRANS(htrans), .HSIZE(hsize), .HPROT(4'b0011), .HBURST(3'b001),
        .HREADY(hready_o[1]), .HRDATA(hrdata[1]), .HREADYOUT(hready_o[1]), .HRESP(hresp[1]));

    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(3)) dut_ws3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[2]), .HADDR(haddr), .HWRITE(hwrite),
        .HWDATA(hwdata), .HTRANS(htrans), .HSIZE(hsize), .HPROT(4'b0011), .HBURST(3'b000),
        .HREADY(hready_o[2]), .HRDATA(hrdata[2]), .HREADYOUT(hready_o[2]), .HRESP(hresp[2]));

    typedef struct {
        int          sel;
        logic        err;
        logic        rd;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    exp_t        exp_q [$];
    int          n_assert = 0;
    int          n_fail = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_wdata = '0;
    int          waits_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drives one address phase (holding it while HREADY is low) and checks the
    // data phase of the previously accepted transfer against the queue head.
    task automatic xfer(input int s, input logic [1:0] tr, input logic wr,
                        input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_rd, input int e_waits);
        exp_t e;
        bit   done;
        int   guard;
        hsel   = '0;
        hsel[s] = 1'b1;
        htrans = tr;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        hwdata = pend_wdata;
        if (tr[1]) begin
            e.sel = s; e.err = e_err; e.rd = !wr; e.rdata = e_rd; e.waits = e_waits;
            exp_q.push_back(e);
        end
        done  = 1'b0;
        guard = 0;
        while (!done) begin
            @(negedge HCLK);
            if (pend) begin
                e = exp_q[0];
                if (hready_o[e.sel] !== 1'b1) begin
                    waits_seen++;
                    chk("wait_hresp", 32'(hresp[e.sel]), 32'(e.err));
                    chk("wait_hrdata", hrdata[e.sel], 32'h0);
                end else begin
                    void'(exp_q.pop_front());
                    chk("waits", 32'(waits_seen), 32'(e.waits));
                    chk("hresp", 32'(hresp[e.sel]), 32'(e.err));
                    chk("hrdata", hrdata[e.sel], (e.rd && !e.err) ? e.rdata : 32'h0);
                    pend = 1'b0;
                    waits_seen = 0;
                end
            end
            if (hready_o[s] === 1'b1) done = 1'b1;
            @(posedge HCLK);
            #1;
            guard++;
            if (!done && guard > 40) begin
                n_assert++;
                n_fail++;
                $error("FAIL timeout: no HREADYOUT within 40 cycles (slave %0d)", s);
                done = 1'b1;
            end
        end
        if (tr[1]) begin
            pend = 1'b1;
            pend_wdata = wd;
        end
    endtask

    task automatic idle(input int s);
        xfer(s, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0, 1'b0, 32'h0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        for (int i = 0; i < 3; i++) begin
            chk("rst_hreadyout", 32'(hready_o[i]), 32'h1);
            chk("rst_hresp", 32'(hresp[i]), 32'h0);
            chk("rst_hrdata", hrdata[i], 32'h0);
        end
        @(posedge HCLK);
        #1;

        // zero wait states: back-to-back write then read of the same word
        xfer(0, HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 1'b0, 32'h0, 0);
        xfer(0, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b0, 32'hDEADBEEF, 0);
        idle(0);

        // BUSY with write intent must be ignored
        xfer(0, HTRANS_BUSY, 1'b1, 32'h10, HSIZE_WORD, 32'h0, 1'b0, 32'h0, 0);
        chk("busy_hreadyout", 32'(hready_o[0]), 32'h1);
        chk("busy_hresp", 32'(hresp[0]), 32'h0);
        hwdata = 32'h0;
        xfer(0, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b0, 32'hDEADBEEF, 0);
        idle(0);

        // byte and halfword lane writes
        xfer(0, HTRANS_NONSEQ, 1'b1, 32'h20, HSIZE_WORD, 32'h11223344, 1'b0, 32'h0, 0);
        xfer(0, HTRANS_NONSEQ, 1'b1, 32'h21, HSIZE_BYTE, 32'h0000AA00, 1'b0, 32'h0, 0);
        xfer(0, HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD, 32'h0, 1'b0, 32'h1122AA44, 0);
        xfer(0, HTRANS_SEQ,    1'b1, 32'h22, HSIZE_HALF, 32'h55660000, 1'b0, 32'h0, 0);
        xfer(0, HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD, 32'h0, 1'b0, 32'h5566AA44, 0);
        idle(0);

        // illegal transfers: two-cycle ERROR, memory untouched
        xfer(0, HTRANS_NONSEQ, 1'b1, 32'h0, HSIZE_WORD, 32'hCAFEF00D, 1'b0, 32'h0, 0);
        xfer(0, HTRANS_NONSEQ, 1'b1, 32'h2, HSIZE_WORD, 32'hFFFFFFFF, 1'b1, 32'h0, 1);
        idle(0);
        xfer(0, HTRANS_NONSEQ, 1'b1, 32'h0, 3'b011, 32'h01010101, 1'b1, 32'h0, 1);
        idle(0);
        xfer(0, HTRANS_NONSEQ, 1'b1, 32'h21, HSIZE_HALF, 32'h00FF0000, 1'b1, 32'h0, 1);
        idle(0);
        xfer(0, HTRANS_NONSEQ, 1'b0, 32'h0, HSIZE_WORD, 32'h0, 1'b0, 32'hCAFEF00D, 0);
        xfer(0, HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD, 32'h0, 1'b0, 32'h5566AA44, 0);
        idle(0);

        // depth boundary
        xfer(0, HTRANS_NONSEQ, 1'b1, 32'hFFC, HSIZE_WORD, 32'h0BADC0DE, 1'b0, 32'h0, 0);
        xfer(0, HTRANS_NONSEQ, 1'b0, 32'hFFC, HSIZE_WORD, 32'h0, 1'b0, 32'h0BADC0DE, 0);
        xfer(0, HTRANS_NONSEQ, 1'b1, 32'h1000, HSIZE_WORD, 32'hFFFFFFFF, 1'b1, 32'h0, 1);
        xfer(0, HTRANS_NONSEQ, 1'b0, 32'h0, HSIZE_WORD, 32'h0, 1'b0, 32'hCAFEF00D, 0);
        idle(0);

        // two wait states
        xfer(1, HTRANS_NONSEQ, 1'b1, 32'h0, HSIZE_WORD, 32'h12345678, 1'b0, 32'h0, 2);
        xfer(1, HTRANS_NONSEQ, 1'b0, 32'h0, HSIZE_WORD, 32'h0, 1'b0, 32'h12345678, 2);
        idle(1);

        // three wait states, then reset during the second wait cycle of a write
        xfer(2, HTRANS_NONSEQ, 1'b1, 32'h40, HSIZE_WORD, 32'hA5A5A5A5, 1'b0, 32'h0, 3);
        idle(2);
        xfer(2, HTRANS_NONSEQ, 1'b1, 32'h40, HSIZE_WORD, 32'hFFFFFFFF, 1'b0, 32'h0, 3);
        htrans = HTRANS_IDLE;
        hwdata = pend_wdata;
        @(negedge HCLK);
        chk("rst_mid_w1", 32'(hready_o[2]), 32'h0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b0;
        @(negedge HCLK);
        chk("rst_mid_w2", 32'(hready_o[2]), 32'h0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("rst_mid_hreadyout", 32'(hready_o[2]), 32'h1);
        chk("rst_mid_hresp", 32'(hresp[2]), 32'h0);
        chk("rst_mid_hrdata", hrdata[2], 32'h0);
        @(posedge HCLK);
        #1;
        void'(exp_q.pop_front());
        pend = 1'b0;
        pend_wdata = '0;
        waits_seen = 0;
        xfer(2, HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_WORD, 32'h0, 1'b0, 32'hA5A5A5A5, 3);
        idle(2);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
